// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 fetch types and constants
//
// Purpose: widths, fetch FSM state encoding and the entry layouts that are
// stored in the instruction buffer and the request tag queue.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // Instruction buffer entry: address of the word plus the word itself.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Tag recorded per issued request so a response can be matched to its
    // address and to the redirect epoch it was issued under.
    typedef struct packed {
        logic            epoch;
        logic [XLEN-1:0] pc;
    } fetch_tag_t;

    function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush and stream-style handshakes
//
// Purpose: DEPTH-entry first-word-fall-through FIFO (DEPTH a power of 2).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush               empties the FIFO at the next posedge (wins over push/pop)
//   s_tdata/s_tvalid    write side; s_tready low only when full and not popping
//   s_tready
//   m_tdata/m_tvalid    read side; m_tdata is the head, m_tvalid means not empty
//   m_tready            pop the head when m_tvalid is also high
//   count               number of stored entries
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic [W-1:0]  s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [W-1:0]  m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          full;
    logic          push;
    logic          pop;

    assign full     = (count_q == CW'(DEPTH));
    assign m_tvalid = (count_q != '0);
    assign m_tdata  = mem[rd_ptr];
    assign count    = count_q;

    // A full FIFO may still accept a word in the same cycle its head leaves.
    assign s_tready = !full || m_tready;
    assign pop      = m_tvalid && m_tready;
    assign push     = s_tvalid && s_tready;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - RV32 instruction fetch sequencer
//
// Purpose: owns the PC, issues word fetches, buffers returned instructions
// for decode and applies execute redirects, discarding stale words by epoch.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   imem_req_valid/ready/addr       fetch request channel (addr = current PC)
//   imem_rsp_valid/data             in-order fetch responses
//   redirect_valid/pc               taken branch/jump target from execute
//   dec_ready                       decode consumes the head this cycle
//   instr_valid/data/pc             instruction buffer head
//   fetch_fault                     sticky misaligned-redirect flag
module fetch_sequencer
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            dec_ready,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic            epoch_q;
    logic [CW-1:0]   outstanding_q;
    logic            fault_q;

    logic            running;
    logic            redirect_fire;
    logic            redirect_bad;
    logic            redirect_good;
    logic [CW:0]     credit_used;
    logic            accept;
    logic            rsp_take;
    logic            rsp_keep;

    fetch_tag_t      tag_in;
    fetch_tag_t      tag_head;
    logic            tag_valid;
    logic            tag_ready;
    logic [CW-1:0]   tag_count_unused;

    fetch_entry_t    entry_in;
    fetch_entry_t    head;
    logic            head_valid;
    logic            buf_ready;
    logic [CW-1:0]   buf_count;

    assign running       = (state_q == RUN);
    assign redirect_fire = running && redirect_valid;
    assign redirect_bad  = redirect_fire && !pc_aligned(redirect_pc);
    assign redirect_good = redirect_fire && pc_aligned(redirect_pc);

    // Every word in flight or buffered holds one credit, so a returning
    // response always finds room in the instruction buffer.
    assign credit_used    = {1'b0, outstanding_q} + {1'b0, buf_count};
    assign imem_req_valid = running && !redirect_valid && tag_ready &&
                            (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // Responses with no recorded request (e.g. left over from before a reset)
    // are ignored.
    assign rsp_take = imem_rsp_valid && tag_valid;
    // A word is kept only if issued under the current epoch; a redirect in
    // the same cycle makes it stale as well.
    assign rsp_keep = rsp_take && (tag_head.epoch == epoch_q) && running &&
                      !redirect_valid && buf_ready;

    assign tag_in   = '{epoch: epoch_q, pc: pc_q};
    assign entry_in = '{pc: tag_head.pc, instr: imem_rsp_data};

    sync_fifo #(
        .W     ($bits(fetch_tag_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .s_tdata  (tag_in),
        .s_tvalid (accept),
        .s_tready (tag_ready),
        .m_tdata  (tag_head),
        .m_tvalid (tag_valid),
        .m_tready (imem_rsp_valid),
        .count    (tag_count_unused)
    );

    sync_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_fire),
        .s_tdata  (entry_in),
        .s_tvalid (rsp_keep),
        .s_tready (buf_ready),
        .m_tdata  (head),
        .m_tvalid (head_valid),
        .m_tready (dec_ready),
        .count    (buf_count)
    );

    assign instr_valid = head_valid;
    assign instr_data  = head_valid ? head.instr : '0;
    assign instr_pc    = head_valid ? head.pc : '0;
    assign fetch_fault = fault_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect_bad) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            epoch_q       <= 1'b0;
            outstanding_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (redirect_good) begin
                pc_q    <= redirect_pc;
                epoch_q <= ~epoch_q;
            end else if (accept) begin
                pc_q <= pc_q + 32'd4;
            end
            if (redirect_bad) begin
                fault_q <= 1'b1;
            end
            outstanding_q <= outstanding_q + CW'(accept) - CW'(rsp_take);
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          since_rst = 0;
    int          rst_run = 0;
    int          stale_left = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_mode = 1;
    int          n_deliv = 0;
    int          n0;
    bit          auto_rsp = 1'b1;
    bit          halted = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] prev_addr;
    logic [31:0] last_deliv;
    logic [31:0] hold_a;
    logic        s_req_valid;
    logic        s_instr_valid;
    logic        s_fault;
    logic [31:0] s_addr;
    logic [31:0] s_instr_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8) return 32'hfe20cce3;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory side, sample outputs, check, update model.
    task automatic cycle();
        int lat;
        if (auto_rsp) begin
            if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'h0;
            end
        end
        case (ready_mode)
            0:       imem_req_ready = 1'($urandom_range(0, 1));
            1:       imem_req_ready = 1'b1;
            default: imem_req_ready = 1'b0;
        endcase
        #1;
        s_req_valid   = imem_req_valid;
        s_addr        = imem_req_addr;
        s_instr_valid = instr_valid;
        s_instr_pc    = instr_pc;
        s_fault       = fetch_fault;
        if (!rst_n) begin
            if (rst_run > 0) begin
                chk("rst_req_valid", imem_req_valid, 0);
                chk("rst_instr_valid", instr_valid, 0);
                chk("rst_instr_data", instr_data, 0);
                chk("rst_instr_pc", instr_pc, 0);
                chk("rst_fault", fetch_fault, 0);
            end
            prev_hold = 1'b0;
        end else begin
            if (since_rst == 0) chk("boot_idle_req", imem_req_valid, 0);
            if (since_rst == 1) begin
                chk("first_req_valid", imem_req_valid, 1);
                chk("first_req_addr", imem_req_addr, RESET_PC);
            end
            chk("fault_flag", fetch_fault, halted);
            if (halted) begin
                chk("halt_no_req", imem_req_valid, 0);
                chk("halt_no_instr", instr_valid, 0);
            end
            if (redirect_valid) chk("redir_no_req", imem_req_valid, 0);
            if (prev_hold && !redirect_valid && !halted) begin
                chk("hold_valid", imem_req_valid, 1);
                chk("hold_addr", imem_req_addr, prev_addr);
            end
            if (imem_rsp_valid && auto_rsp) begin
                mq.delete(0);
                if (stale_left > 0) stale_left--;
            end
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req);
                exp_req = exp_req + 32'd4;
                lat = $urandom_range(lat_min, lat_max);
                mq.push_back('{addr: imem_req_addr, due: cyc + lat});
                chk("inflight_bound", 32'(mq.size() <= 2), 1);
            end
            if (instr_valid && dec_ready && !redirect_valid) begin
                chk("instr_pc", instr_pc, exp_pc);
                chk("instr_data", instr_data, mem_word(exp_pc));
                last_deliv = instr_pc;
                exp_pc     = exp_pc + 32'd4;
                n_deliv++;
            end
            if (redirect_valid && !halted) begin
                if (redirect_pc[1:0] != 2'b00) begin
                    halted = 1'b1;
                end else begin
                    exp_pc     = redirect_pc;
                    exp_req    = redirect_pc;
                    stale_left = mq.size();
                end
            end
            prev_hold = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;
        end
        @(posedge clk);
        if (!rst_n) begin
            rst_run++;
            since_rst  = 0;
            mq.delete();
            stale_left = 0;
            halted     = 1'b0;
            exp_pc     = RESET_PC;
            exp_req    = RESET_PC;
        end else begin
            rst_run = 0;
            since_rst++;
        end
        #1;
        cyc++;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b1;
        exp_pc         = RESET_PC;
        exp_req        = RESET_PC;
        prev_addr      = 32'h0;
        last_deliv     = 32'hFFFF_FFFF;

        // Reset release with an ideal memory: first request, t+2 latency.
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (4) cycle();
        chk("t1_latency_valid", s_instr_valid, 1);
        chk("t1_latency_pc", s_instr_pc, RESET_PC);

        // Run until the branch word at 0x8 is consumed, then redirect to 0x0
        // while decode stalls: buffer fills with 0x0/0x4 and fetch parks at 0x8.
        for (int k = 0; k < 30 && last_deliv != 32'h8; k++) cycle();
        chk("t3_reached_8", last_deliv, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        cycle();
        redirect_valid = 1'b0;
        repeat (8) cycle();
        chk("t2_req_idle", s_req_valid, 0);
        chk("t2_addr_held", s_addr, 32'h8);
        chk("t2_head_valid", s_instr_valid, 1);
        chk("t3_head_pc", s_instr_pc, 32'h0);
        dec_ready = 1'b1;
        repeat (8) cycle();

        // Memory stalls with a request pending.
        ready_mode = 2;
        repeat (3) cycle();
        chk("t4_pending", s_req_valid, 1);
        hold_a = s_addr;
        repeat (3) begin
            cycle();
            chk("t4_valid", s_req_valid, 1);
            chk("t4_addr", s_addr, hold_a);
        end
        ready_mode = 1;
        cycle();
        cycle();
        chk("t4_advance", s_addr, hold_a + 32'd4);

        // Randomized traffic with random latency, stalls and redirects.
        ready_mode = 0;
        lat_max    = 4;
        for (int i = 0; i < 700; i++) begin
            dec_ready = ($urandom_range(0, 3) != 0);
            if (stale_left == 0 && $urandom_range(0, 11) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end else begin
                redirect_valid = 1'b0;
            end
            cycle();
        end
        redirect_valid = 1'b0;
        dec_ready      = 1'b1;

        // PC wraparound.
        for (int k = 0; k < 20 && stale_left != 0; k++) cycle();
        chk("wrap_no_stale", stale_left, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cycle();
        redirect_valid = 1'b0;
        n0 = n_deliv;
        repeat (30) cycle();
        chk("wrap_crossed", 32'(n_deliv - n0 >= 3), 1);

        // Misaligned redirect halts fetch.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        cycle();
        redirect_valid = 1'b0;
        repeat (10) cycle();
        chk("t5_fault", s_fault, 1);
        chk("t5_no_req", s_req_valid, 0);

        // Reset with two requests in flight; responses arrive during/after reset.
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n      = 1'b1;
        ready_mode = 1;
        lat_min    = 6;
        lat_max    = 6;
        for (int k = 0; k < 20 && mq.size() < 2; k++) cycle();
        chk("t6_two_inflight", 32'(mq.size()), 2);
        auto_rsp       = 1'b0;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        chk("t6_boot_no_instr", s_instr_valid, 0);
        imem_rsp_valid = 1'b0;
        auto_rsp       = 1'b1;
        lat_min        = 1;
        lat_max        = 2;
        cycle();
        chk("t6_first_req", s_req_valid, 1);
        chk("t6_first_addr", s_addr, RESET_PC);
        n0 = n_deliv;
        repeat (15) cycle();
        chk("t6_delivered", 32'(n_deliv > n0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
